// File: rtl/sha3_pkg.sv
// Shared SHA-3 round definitions: geometry, Keccak rho offsets, rotate FSM states.
package sha3_pkg;

  localparam int LANES  = 25;
  localparam int SLICES = 64;
  localparam int ADDR_W = 6;
  localparam int LANE_W = 5;

  // Indexed by lane i = 5y + x.
  localparam logic [ADDR_W-1:0] RHO_OFFSET [0:LANES-1] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  typedef enum logic [2:0] {
    ROT_IDLE,
    ROT_ARM,
    ROT_READ,
    ROT_LAST,
    ROT_WRITE,
    ROT_DONE
  } rot_state_t;

endpackage

// File: rtl/rotate_controller.sv
// Rho stage sequencer: start handshake, per-lane read/capture, per-slice write,
// and the init/enable controls for the lane (i) and slice (z) counters.
module rotate_controller
  import sha3_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic i_first,
  input  logic i_last,
  input  logic z_last,
  output logic i_clr,
  output logic i_inc,
  output logic z_clr,
  output logic z_inc,
  output logic rd_en,
  output logic cap_en,
  output logic cap_last,
  output logic wr_en,
  output logic busy,
  output logic ready
);

  rot_state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ROT_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    i_clr     = 1'b0;
    i_inc     = 1'b0;
    z_clr     = 1'b0;
    z_inc     = 1'b0;
    rd_en     = 1'b0;
    cap_en    = 1'b0;
    cap_last  = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b0;
    ready     = 1'b0;
    case (state)
      ROT_IDLE: begin
        if (start) state_nxt = ROT_ARM;
      end
      ROT_ARM: begin
        busy = 1'b1;
        if (!start) begin
          z_clr     = 1'b1;
          i_clr     = 1'b1;
          state_nxt = ROT_READ;
        end
      end
      ROT_READ: begin
        busy   = 1'b1;
        rd_en  = 1'b1;
        // Read data lags the address by one cycle, so lane i-1 lands now.
        cap_en = !i_first;
        if (i_last) state_nxt = ROT_LAST;
        else        i_inc     = 1'b1;
      end
      ROT_LAST: begin
        busy      = 1'b1;
        cap_en    = 1'b1;
        cap_last  = 1'b1;
        state_nxt = ROT_WRITE;
      end
      ROT_WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (z_last) begin
          state_nxt = ROT_DONE;
        end else begin
          z_inc     = 1'b1;
          i_clr     = 1'b1;
          state_nxt = ROT_READ;
        end
      end
      ROT_DONE: begin
        ready     = 1'b1;
        state_nxt = ROT_IDLE;
      end
      default: state_nxt = ROT_IDLE;
    endcase
  end

endmodule

// File: rtl/rotate_stage.sv
// Keccak rho step: gathers each output slice lane-by-lane from rotated input
// slice addresses, then writes it; 27 cycles per slice, 64 slices per run.
module rotate_stage #(
  parameter int LANES  = 25,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [LANES-1:0]  rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LANES-1:0]  wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              ready
);

  import sha3_pkg::*;

  logic [LANE_W-1:0] i;
  logic [ADDR_W-1:0] z;
  logic [LANES-1:0]  slice_buf;
  logic [LANE_W-1:0] cap_idx;
  logic [ADDR_W-1:0] rho;
  logic i_first, i_last, z_last;
  logic i_clr, i_inc, z_clr, z_inc, cap_en, cap_last;

  rotate_controller u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .i_first  (i_first),
    .i_last   (i_last),
    .z_last   (z_last),
    .i_clr    (i_clr),
    .i_inc    (i_inc),
    .z_clr    (z_clr),
    .z_inc    (z_inc),
    .rd_en    (rd_en),
    .cap_en   (cap_en),
    .cap_last (cap_last),
    .wr_en    (wr_en),
    .busy     (busy),
    .ready    (ready)
  );

  assign i_first = (i == '0);
  assign i_last  = (i == LANE_W'(LANES - 1));
  assign z_last  = (z == ADDR_W'(SLICES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i <= '0;
      z <= '0;
    end else begin
      if (i_clr)      i <= '0;
      else if (i_inc) i <= i + LANE_W'(1);
      if (z_clr)      z <= '0;
      else if (z_inc) z <= z + ADDR_W'(1);
    end
  end

  // Output bit z of lane i comes from input slice z - r[i]; 6-bit wrap is the mod 64.
  assign rho     = RHO_OFFSET[i];
  assign rd_addr = rd_en ? (z - rho) : '0;

  assign cap_idx = cap_last ? LANE_W'(LANES - 1) : (i - LANE_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_buf <= '0;
    end else if (cap_en) begin
      for (int b = 0; b < LANES; b++) begin
        if (cap_idx == LANE_W'(b)) slice_buf[b] <= rd_data[b];
      end
    end
  end

  assign wr_addr = wr_en ? z : '0;
  assign wr_data = wr_en ? slice_buf : '0;

endmodule

// File: tb/tb_rotate_stage.sv
// Bench for rotate_stage: directed one-hot vectors, all-ones, handshake and reset corners, random states vs rho model.
module tb_rotate_stage;

  localparam int RHO [0:24] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                                41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  rd_addr, wr_addr;
  logic        rd_en, wr_en, busy, ready;
  logic [24:0] rd_data, wr_data;

  logic [24:0] in_mem  [64];
  logic [24:0] out_mem [64];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int in_z;
    int in_bit;
    int out_z;
  } vec_t;

  rotate_stage dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .busy    (busy),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read input memory.
  always @(posedge clk) if (rd_en) rd_data <= in_mem[rd_addr];

  task automatic chk(input string nm, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [24:0] gold(input int z);
    logic [24:0] w;
    w = '0;
    for (int l = 0; l < 25; l++) w[l] = in_mem[(z - RHO[l] + 64) % 64][l];
    return w;
  endfunction

  task automatic check_gold(input string nm);
    int bad;
    bad = 0;
    for (int z = 0; z < 64; z++) if (out_mem[z] !== gold(z)) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic rand_state();
    for (int z = 0; z < 64; z++) in_mem[z] = 25'($urandom);
  endtask

  function automatic longint outs();
    return longint'({rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, ready});
  endfunction

  // One full run; every sample is taken at the falling edge.
  task automatic do_run(input int hold, input bit toggle, output int n_wr, output int n_rdy,
                        output int lat, output bit ok_order, output bit early);
    int first_rd, rdy_t, tail;
    bit seen;
    n_wr = 0; n_rdy = 0; ok_order = 1'b1; early = 1'b0;
    first_rd = -1; rdy_t = -1; tail = 0; seen = 1'b0;
    for (int z = 0; z < 64; z++) out_mem[z] = 25'h0F0F0F0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (rd_en) early = 1'b1;
    end
    start = 1'b0;
    for (int t = 1; t < 4000 && tail < 40; t++) begin
      @(negedge clk);
      if (toggle) start = (t >= 30 && t < 60) ? t[0] : 1'b0;
      if (rd_en && first_rd < 0) first_rd = t;
      if (wr_en) begin
        if (wr_addr != 6'(n_wr)) ok_order = 1'b0;
        out_mem[wr_addr] = wr_data;
        n_wr++;
      end
      if (ready) begin
        n_rdy++;
        rdy_t = t;
        seen = 1'b1;
      end
      if (seen) tail++;
    end
    start = 1'b0;
    lat = (first_rd < 0 || rdy_t < 0) ? -1 : rdy_t - first_rd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int n_wr, n_rdy, lat, bad, nwr_after, guard;
    bit ok_order, early;
    logic [24:0] e;

    vecs[0] = '{0, 1, 1};
    vecs[1] = '{63, 5, 35};
    vecs[2] = '{63, 2, 61};
    vecs[3] = '{10, 0, 10};
    vecs[4] = '{20, 24, 34};
    vecs[5] = '{50, 3, 14};

    rst = 1'b0;
    start = 1'b0;
    for (int z = 0; z < 64; z++) in_mem[z] = '0;

    // Async reset mid-cycle with start high, while the FSM sits in ARM.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("arm_busy", busy, 1);
    #2 rst = 1'b1;
    #1 chk("reset_outputs", outs(), 0);
    repeat (3) @(negedge clk);
    chk("reset_hold_outputs", outs(), 0);
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", outs(), 0);

    foreach (vecs[v]) begin
      for (int z = 0; z < 64; z++) in_mem[z] = '0;
      in_mem[vecs[v].in_z][vecs[v].in_bit] = 1'b1;
      do_run(1, 1'b0, n_wr, n_rdy, lat, ok_order, early);
      bad = 0;
      for (int z = 0; z < 64; z++) begin
        e = '0;
        if (z == vecs[v].out_z) e[vecs[v].in_bit] = 1'b1;
        if (out_mem[z] !== e) bad++;
      end
      chk($sformatf("onehot_vec%0d", v), bad, 0);
      chk($sformatf("onehot_wr_cnt%0d", v), n_wr, 64);
    end

    // All ones: full-run timing and write order.
    for (int z = 0; z < 64; z++) in_mem[z] = '1;
    do_run(1, 1'b0, n_wr, n_rdy, lat, ok_order, early);
    bad = 0;
    for (int z = 0; z < 64; z++) if (out_mem[z] !== 25'h1FFFFFF) bad++;
    chk("ones_data", bad, 0);
    chk("ones_wr_cnt", n_wr, 64);
    chk("ones_wr_order", ok_order, 1);
    chk("ones_ready_cnt", n_rdy, 1);
    chk("ones_ready_cycle", lat, 1728);

    // start held high for 10 cycles.
    rand_state();
    do_run(10, 1'b0, n_wr, n_rdy, lat, ok_order, early);
    chk("hold_no_rd", early, 0);
    chk("hold_ready_cycle", lat, 1728);
    check_gold("hold_data");

    // start toggled during READ.
    rand_state();
    do_run(1, 1'b1, n_wr, n_rdy, lat, ok_order, early);
    chk("toggle_ready_cnt", n_rdy, 1);
    chk("toggle_wr_cnt", n_wr, 64);
    chk("toggle_ready_cycle", lat, 1728);
    check_gold("toggle_data");

    // Reset while reading slice 10.
    rand_state();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_wr = 0;
    guard = 0;
    while (n_wr < 10 && guard < 1000) begin
      @(negedge clk);
      if (wr_en) n_wr++;
      guard++;
    end
    chk("abort_reach_slice10", n_wr, 10);
    repeat (5) @(negedge clk);
    chk("abort_in_read", rd_en, 1);
    #2 rst = 1'b1;
    #1 chk("abort_reset_outputs", outs(), 0);
    nwr_after = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (t == 3) rst = 1'b0;
      if (wr_en) nwr_after++;
    end
    chk("abort_no_wr", nwr_after, 0);
    do_run(1, 1'b0, n_wr, n_rdy, lat, ok_order, early);
    chk("rerun_wr_order", ok_order, 1);
    chk("rerun_wr_cnt", n_wr, 64);
    chk("rerun_ready_cnt", n_rdy, 1);
    check_gold("rerun_data");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rotate_stage.md
# rotate_stage

Rho (lane-rotation) step of the SHA-3 encoder round, sitting directly upstream of the permute (pi) stage. Reads the 1600-bit state slice-by-slice from the input state memory and rotates each of the 25 lanes along z by its fixed Keccak rho offset. Writes the rotated slices to the output state memory, which the permute stage then consumes. Uses the same start/ready handshake as the rest of the round, so its `ready` can drive the permute stage's `start`.

## Interface
- `LANES`, 25, bits per slice word (lanes); only the default is supported.
- `ADDR_W`, 6, slice address width (64 slices); only the default is supported.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: level request; a run begins after `start` is seen high and then low.
- `rd_addr` out ADDR_W: input-memory slice address.
- `rd_en` out 1: input-memory read enable.
- `rd_data` in LANES: input-memory slice word, valid the cycle after `rd_en`/`rd_addr` (synchronous read).
- `wr_addr` out ADDR_W: output-memory slice address.
- `wr_data` out LANES: rotated slice word.
- `wr_en` out 1: output-memory write strobe.
- `busy` out 1: high from ARM through WRITE of slice 63.
- `ready` out 1: one-cycle completion pulse.

## Operation
- Bit i of a slice word is lane (x,y) with i = 5y + x. Output A'[i][z] = A[i][(z − r[i]) mod 64].
- r[0..24] = 0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39, 41,45,15,21,8, 18,2,61,56,14.
- FSM states:
  - IDLE: waits for `start`=1, then goes to ARM.
  - ARM: waits for `start`=0; clears z, then goes to READ.
  - READ: 25 cycles, lane counter i = 0..24. Drives `rd_en`=1 and `rd_addr` = (z − r[i]) mod 64 using natural 6-bit wrap-around subtraction. Each cycle with i>0 also captures `rd_data[i−1]` into bit i−1 of the slice buffer. After i=24, goes to LAST.
  - LAST: captures `rd_data[24]`; `rd_en`=0. Goes to WRITE.
  - WRITE: drives `wr_en`=1, `wr_addr`=z, `wr_data`=buffer. If z=63, goes to DONE; otherwise increments z, clears i, and returns to READ.
  - DONE: drives `ready`=1 for one cycle, then goes to IDLE.
- The input memory is only read and the output memory only written; the two memories are distinct, so there are no read/write hazards.
- `start` activity outside IDLE/ARM is ignored. A new run starts only after DONE → IDLE.
- `rd_addr`, `wr_addr` and `wr_data` are 0 whenever their strobe is low.

## Timing
- Reset: state IDLE, z=0, i=0, buffer=0. Every output is 0.
- Reset mid-run: the block returns to IDLE immediately. No further `wr_en` is issued, and the output memory is left partially written. The next run starts again from slice 0.
- Per slice: 25 READ + 1 LAST + 1 WRITE = 27 cycles. Full run: 64 × 27 = 1728 cycles from the first READ cycle to the end of the last WRITE.
- `ready` is high in cycle 1729, counting the first READ cycle as cycle 1.
- The first READ cycle is the cycle after ARM samples `start`=0. Minimum start-to-ready: `start` high 1 cycle gives 1 IDLE + 1 ARM + 1728 + 1 DONE.
- `wr_en` pulses exactly 64 times per run, with `wr_addr` ascending 0..63.

## Structure
- Shared package `sha3_pkg`:
  - `RHO_OFFSET[0:24]` constant table.
  - `LANES` = 25, `SLICES` = 64, `ADDR_W` = 6.
  - rotate FSM state encoding.
- Sub-module `rotate_controller`: the FSM together with the i/z counter control (init/enable/carry-out), matching the controller/datapath split used by the other round stages.
- Top `rotate_stage`:
  - counters.
  - offset lookup.
  - address subtractor.
  - 25-bit slice buffer.

## Test plan
- Reset: assert `rst` mid-cycle with `start`=1. All outputs are 0 asynchronously, and `ready` stays 0 until a full run completes.
- Single bit, no wrap: input slice 0 bit 1 = 1, everything else 0. Output slice 1 = 25'h0000002; all other slices are 0.
- Wrap-around:
  - Input slice 63 bit 5 = 1 (r=36) → output slice 35 bit 5 = 1.
  - Input slice 63 bit 2 = 1 (r=62) → output slice 61 bit 2 = 1.
  - Nothing else is set in the output.
- All-ones input gives all-ones output. Check 64 `wr_en` pulses with `wr_addr` 0..63, and a single `ready` pulse in cycle 1729 after the first READ.
- Handshake:
  - `start` held high for 10 cycles → no `rd_en` until `start` falls.
  - `start` toggled during READ → no restart and no extra `ready`.
- Reset at slice 10 (during READ): no `wr_en` after reset. A following start rewrites slices 0..63 correctly against the golden rho model for a random state.
